// File: rtl/lm70_pkg.sv
// Shared LM70 definitions: frame geometry, FSM encoding, and the raw-word to display conversion.
// Pure combinational helpers; no state.
package lm70_pkg;

    localparam int LM70_FRAME_BITS = 16;
    localparam int LM70_DEG_MSB    = 15;
    localparam int LM70_DEG_LSB    = 7;
    localparam int DISP_MAX_DEG    = 99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    typedef struct packed {
        logic [7:0] deg_c;
        logic       neg;
        logic       ovf;
    } temp_t;

    // Whole degrees live in the top 9 bits as two's complement; the display only handles 0..99.
    function automatic temp_t lm70_convert(input logic [LM70_FRAME_BITS-1:0] raw);
        logic [8:0] deg;
        logic [8:0] mag;
        temp_t      t;
        deg     = raw[LM70_DEG_MSB:LM70_DEG_LSB];
        t.neg   = deg[8];
        mag     = t.neg ? (~deg + 9'd1) : deg;
        t.ovf   = (mag > 9'(DISP_MAX_DEG));
        t.deg_c = t.ovf ? 8'(DISP_MAX_DEG) : mag[7:0];
        return t;
    endfunction

endpackage

// File: rtl/lm70_spi_reader_if.sv
// Three-wire LM70 SPI bus: chip select, clock and the sensor's data line.
// Master drives cs_n/sck and samples miso; the sensor side is the slave.
interface lm70_spi_reader_if;
    logic cs_n;
    logic sck;
    logic miso;

    modport master (output cs_n, output sck, input miso);
    modport slave  (input cs_n, input sck, output miso);
endinterface

// File: rtl/lm70_spi_reader_spi_clk_gen.sv
// SCK generator: counts CLK_DIV-cycle half-periods while run is high, toggling sck when tog_en.
// Strobes are combinational from the counter; sck is a flop and returns low whenever run drops.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic tog_en,
    output logic sck,
    output logic rise,
    output logic hp_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    always_comb begin
        hp_done = run && (cnt_q == CW'(CLK_DIV - 1));
        rise    = hp_done && tog_en && !sck_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        if (!run) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (hp_done) begin
            cnt_d = '0;
            if (tog_en) begin
                sck_d = !sck_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/lm70_spi_reader.sv
// LM70 SPI reader: runs a 16-bit read frame on start or periodic trigger and converts it to display degrees.
// Latency 1+CLK_DIV+2*NBITS*CLK_DIV cycles to temp_valid; triggers while busy are dropped.
module lm70_spi_reader
    import lm70_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int NBITS         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       auto_en,
    input  logic                       start,
    lm70_spi_reader_if.master          spi,
    output logic                       busy,
    output logic [LM70_FRAME_BITS-1:0] temp_raw,
    output logic [7:0]                 temp_c,
    output logic                       temp_neg,
    output logic                       temp_ovf,
    output logic                       temp_valid
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int HW = $clog2(2 * NBITS);

    state_t                      state_q, state_d;
    logic [PW-1:0]               per_q, per_d;
    logic [HW-1:0]               hp_q, hp_d;
    logic [LM70_FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [LM70_FRAME_BITS-1:0]  raw_q, raw_d;
    temp_t                       res_q, res_d;
    logic                        vld_q, vld_d;
    logic                        cs_n_q, cs_n_d;

    logic run, tog_en, sck, rise, hp_done;
    logic per_wrap, trig;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .tog_en  (tog_en),
        .sck     (sck),
        .rise    (rise),
        .hp_done (hp_done)
    );

    always_comb begin
        run      = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
        tog_en   = (state_q == ST_SHIFT);
        per_wrap = (per_q == PW'(SAMPLE_PERIOD - 1));
        per_d    = per_wrap ? '0 : per_q + PW'(1);
        trig     = start || (per_wrap && auto_en);

        state_d  = state_q;
        hp_d     = hp_q;
        shreg_d  = shreg_q;
        raw_d    = raw_q;
        res_d    = res_q;
        vld_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_SETUP;
                    hp_d    = '0;
                end
            end
            ST_SETUP: begin
                if (hp_done) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (hp_done) begin
                    hp_d = hp_q + HW'(1);
                    // Last half-period ends with sck low; results are loaded so they
                    // appear in the LATCH cycle together with the strobe.
                    if (hp_q == HW'(2 * NBITS - 1)) begin
                        state_d = ST_LATCH;
                        raw_d   = shreg_q;
                        res_d   = lm70_convert(shreg_q);
                        vld_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rise) begin
            shreg_d = {shreg_q[LM70_FRAME_BITS-2:0], spi.miso};
        end

        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            hp_q    <= '0;
            shreg_q <= '0;
            raw_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hp_q    <= hp_d;
            shreg_q <= shreg_d;
            raw_q   <= raw_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign spi.cs_n   = cs_n_q;
    assign spi.sck    = sck;
    assign busy       = (state_q != ST_IDLE);
    assign temp_raw   = raw_q;
    assign temp_c     = res_q.deg_c;
    assign temp_neg   = res_q.neg;
    assign temp_ovf   = res_q.ovf;
    assign temp_valid = vld_q;

endmodule

// File: tb/tb_lm70_spi_reader.sv
// Bench for lm70_spi_reader: LM70 sensor models, directed and random frames, reset, auto mode, SCK timing.
module tb_lm70_spi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, auto_en, auto_off;
    logic        start0, start1, start3;
    logic [15:0] word;

    logic        busy0, busy1, busy3;
    logic [15:0] raw0, raw1, raw3;
    logic [7:0]  c0, c1, c3;
    logic        neg0, neg1, neg3, ovf0, ovf1, ovf3, vld0, vld1, vld3;

    int n_cmp = 0;
    int n_err = 0;

    lm70_spi_reader_if spi0 ();
    lm70_spi_reader_if spi1 ();
    lm70_spi_reader_if spi3 ();

    lm70_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .NBITS(16)) u0 (
        .clk(clk), .rst(rst), .auto_en(auto_en), .start(start0), .spi(spi0),
        .busy(busy0), .temp_raw(raw0), .temp_c(c0), .temp_neg(neg0),
        .temp_ovf(ovf0), .temp_valid(vld0));

    lm70_spi_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(128), .NBITS(16)) u1 (
        .clk(clk), .rst(rst), .auto_en(auto_off), .start(start1), .spi(spi1),
        .busy(busy1), .temp_raw(raw1), .temp_c(c1), .temp_neg(neg1),
        .temp_ovf(ovf1), .temp_valid(vld1));

    lm70_spi_reader #(.CLK_DIV(3), .SAMPLE_PERIOD(128), .NBITS(16)) u3 (
        .clk(clk), .rst(rst), .auto_en(auto_off), .start(start3), .spi(spi3),
        .busy(busy3), .temp_raw(raw3), .temp_c(c3), .temp_neg(neg3),
        .temp_ovf(ovf3), .temp_valid(vld3));

    // Sensor model: MSB presented when cs_n falls, next bit after each sck fall.
    int fall0 = 0, fall1 = 0, fall3 = 0;
    always @(negedge spi0.sck or posedge spi0.cs_n) fall0 = spi0.cs_n ? 0 : fall0 + 1;
    always @(negedge spi1.sck or posedge spi1.cs_n) fall1 = spi1.cs_n ? 0 : fall1 + 1;
    always @(negedge spi3.sck or posedge spi3.cs_n) fall3 = spi3.cs_n ? 0 : fall3 + 1;
    assign spi0.miso = (fall0 < 16) ? word[4'(15 - fall0)] : 1'b0;
    assign spi1.miso = (fall1 < 16) ? word[4'(15 - fall1)] : 1'b0;
    assign spi3.miso = (fall3 < 16) ? word[4'(15 - fall3)] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion straight from the arithmetic rules, in plain integers.
    function automatic void ref_model(input logic [15:0] w, output int c, output bit n, output bit o);
        int v;
        v = int'(w[15:7]);
        if (v >= 256) v = v - 512;
        n = (v < 0);
        if (n) v = -v;
        o = (v > 99);
        c = o ? 99 : v;
    endfunction

    function automatic logic get_sck(input int w);
        case (w)
            1: return spi1.sck;
            3: return spi3.sck;
            default: return spi0.sck;
        endcase
    endfunction

    function automatic logic get_csn(input int w);
        case (w)
            1: return spi1.cs_n;
            3: return spi3.cs_n;
            default: return spi0.cs_n;
        endcase
    endfunction

    function automatic logic get_vld(input int w);
        case (w)
            1: return vld1;
            3: return vld3;
            default: return vld0;
        endcase
    endfunction

    // Called at a negedge; start is high for exactly one rising edge.
    task automatic pulse_start(input int w);
        case (w)
            1: start1 = 1'b1;
            3: start3 = 1'b1;
            default: start0 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w);
        int lat, exp_c;
        bit exp_n, exp_o;
        word = w;
        ref_model(w, exp_c, exp_n, exp_o);
        pulse_start(0);
        chk("busy_in_frame", busy0, 1);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (vld0) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("latency", lat, 67);
        chk("temp_raw", raw0, w);
        chk("temp_c", c0, exp_c);
        chk("temp_neg", neg0, exp_n);
        chk("temp_ovf", ovf0, exp_o);
        chk("busy_in_latch", busy0, 1);
        @(negedge clk);
        chk("valid_one_cycle", vld0, 0);
        chk("idle_after", busy0, 0);
    endtask

    task automatic timing_check(input int w, input int d);
        int cs_low, rises, run, bad_hi, bad_lo, first_lo, vld_at, n_lo;
        logic prev, s, cn;
        cs_low = 0; rises = 0; run = 0; bad_hi = 0; bad_lo = 0;
        first_lo = -1; vld_at = -1; n_lo = 0; prev = 1'b0;
        word = 16'hA5C3;
        pulse_start(w);
        for (int c = 1; c <= 36 * d + 8; c++) begin
            s  = get_sck(w);
            cn = get_csn(w);
            if (get_vld(w) && vld_at < 0) vld_at = c;
            if (!cn) begin
                cs_low++;
                if (run == 0 || s == prev) begin
                    run++;
                end else begin
                    if (prev) begin
                        if (run != d) bad_hi++;
                    end else begin
                        if (n_lo == 0) first_lo = run;
                        else if (run != d) bad_lo++;
                        n_lo++;
                    end
                    run = 1;
                end
                if (s && !prev) rises++;
                prev = s;
            end else if (run > 0) begin
                if (!prev || run != d) bad_hi++;
                run  = 0;
                prev = 1'b0;
            end
            @(negedge clk);
        end
        chk("cs_low_cycles", cs_low, 33 * d);
        chk("sck_rises", rises, 16);
        chk("sck_high_len_errs", bad_hi, 0);
        chk("sck_low_len_errs", bad_lo, 0);
        chk("setup_plus_first_low", first_lo, 2 * d);
        chk("div_latency", vld_at, 1 + 33 * d);
    endtask

    initial begin
        int found, last, nv, seen;
        rst = 1'b1; auto_en = 1'b0; auto_off = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start3 = 1'b0; word = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi0.cs_n, 1);
        chk("rst_sck", spi0.sck, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_valid", vld0, 0);
        chk("rst_raw", raw0, 0);
        chk("rst_c", c0, 0);
        chk("rst_neg", neg0, 0);
        chk("rst_ovf", ovf0, 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(16'h0C80);
        run_frame(16'hFB00);
        run_frame(16'h4B00);
        run_frame(16'h3180);
        run_frame(16'h3200);
        run_frame(16'hCE80);
        run_frame(16'h8000);
        for (int i = 0; i < 8; i++) run_frame(16'($urandom));
        run_frame(16'h1234);

        pulse_start(0);
        repeat (20) @(negedge clk);
        chk("mid_busy", busy0, 1);
        chk("mid_cs_low", spi0.cs_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", spi0.cs_n, 1);
        chk("mid_rst_sck", spi0.sck, 0);
        chk("mid_rst_valid", vld0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_raw", raw0, 0);
        chk("mid_rst_c", c0, 0);
        chk("mid_rst_busy", busy0, 0);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (vld0) seen++;
            @(negedge clk);
        end
        chk("no_valid_after_rst", seen, 0);

        timing_check(1, 1);
        chk("div1_raw", raw1, 16'hA5C3);
        timing_check(3, 3);
        chk("div3_raw", raw3, 16'hA5C3);

        auto_en = 1'b1;
        word = 16'h0C80;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            if (vld0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("auto_first", found, 1);
        last = 0; nv = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start0 = busy0;
            if (vld0) begin
                nv++;
                chk("auto_interval", c - last, 200);
                last = c;
            end
        end
        start0 = 1'b0;
        chk("auto_count", nv, 3);
        chk("auto_c", c0, 25);

        found = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (busy0) begin
                found = 1;
                break;
            end
        end
        chk("auto_next_busy", found, 1);
        auto_en = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (vld0) begin
                found = 1;
                break;
            end
        end
        chk("auto_off_frame_completes", found, 1);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (vld0) seen++;
        end
        chk("auto_off_quiet", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
